// File: rtl/led_cnt_pkg.sv
// Shared definitions for the multi-channel LED counter.
//   led_mode_e : per-channel run-time mode (OFF/ON/BLINK/PULSE)
//   MAX_LEDS   : upper bound on the number of channels the top accepts
package led_cnt_pkg;

  localparam int MAX_LEDS = 16;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PULSE = 2'd3
  } led_mode_e;

endpackage

// File: rtl/led_cnt_chan.sv
// One LED channel: mode/divider registers, a free-running counter and
// registered led/wrap outputs.
// Ports:
//   clk100  in  clock, rising edge
//   rst     in  synchronous active-high reset
//   ld      in  load strobe: takes mode/div this edge and restarts the phase
//   mode    in  new mode (led_mode_e encoding)
//   div     in  new terminal count
//   led_o   out registered LED drive
//   wrap_o  out registered one-cycle pulse on counter wrap
module led_cnt_chan
  import led_cnt_pkg::*;
#(
  parameter int               CNT_W    = 27,
  parameter logic [CNT_W-1:0] DEF_DIV  = CNT_W'(32'd49_999_999),
  parameter led_mode_e        DEF_MODE = MODE_BLINK
) (
  input  logic             clk100,
  input  logic             rst,
  input  logic             ld,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] div,
  output logic             led_o,
  output logic             wrap_o
);

  led_mode_e        mode_q, mode_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             led_q, led_d;
  logic             wrap_q, wrap_d;
  logic             term;

  // cnt never passes div, so equality is the only terminal test needed.
  assign term = (cnt_q == div_q);

  always_comb begin
    mode_d = mode_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    led_d  = led_q;
    wrap_d = 1'b0;
    if (ld) begin
      // A load beats a terminal event on the same edge: the phase restarts
      // from zero with the LED dark and no wrap pulse.
      mode_d = led_mode_e'(mode);
      div_d  = div;
      cnt_d  = '0;
      led_d  = 1'b0;
    end else begin
      unique case (mode_q)
        MODE_OFF: begin
          cnt_d = '0;
          led_d = 1'b0;
        end
        MODE_ON: begin
          cnt_d = '0;
          led_d = 1'b1;
        end
        MODE_BLINK: begin
          if (term) begin
            cnt_d  = '0;
            wrap_d = 1'b1;
            led_d  = ~led_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        MODE_PULSE: begin
          if (term) begin
            cnt_d  = '0;
            wrap_d = 1'b1;
            led_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            led_d = 1'b0;
          end
        end
        default: begin
          cnt_d = '0;
          led_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      mode_q <= DEF_MODE;
      div_q  <= DEF_DIV;
      cnt_q  <= '0;
      led_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      led_q  <= led_d;
      wrap_q <= wrap_d;
    end
  end

  assign led_o  = led_q;
  assign wrap_o = wrap_q;

endmodule

// File: rtl/led_cnt_multi.sv
// NUM_LEDS independent LED channels, each with a run-time mode and divider,
// configured through a single-cycle write strobe. Also drives a constant
// version word.
// Ports:
//   clk100    in  100 MHz clock, rising edge
//   rst       in  synchronous active-high reset
//   cfg_we    in  config write strobe
//   cfg_sel   in  target channel index (writes to indices >= NUM_LEDS are ignored)
//   cfg_mode  in  0=OFF 1=ON 2=BLINK 3=PULSE
//   cfg_div   in  terminal count for the channel counter
//   leds_o    out registered LED drive, bit i = channel i
//   wrap_o    out registered wrap pulse, bit i = channel i
//   version   out constant VERS
//
// Write handshake: there is no ready. cfg_we is a one-cycle strobe and the
// selected channel always accepts cfg_mode/cfg_div on the edge where cfg_we
// is high; back-to-back strobes are accepted every cycle. A strobe on an
// edge where rst is high is dropped.
module led_cnt_multi
  import led_cnt_pkg::*;
#(
  parameter int          NUM_LEDS = 2,
  parameter int          CNT_W    = 27,
  parameter logic [31:0] DEF_DIV  = 32'd49_999_999,
  parameter led_mode_e   DEF_MODE = MODE_BLINK,
  parameter logic [31:0] VERS     = 32'hCCCC_0100
) (
  input  logic                clk100,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_sel,
  input  logic [1:0]          cfg_mode,
  input  logic [CNT_W-1:0]    cfg_div,
  output logic [NUM_LEDS-1:0] leds_o,
  output logic [NUM_LEDS-1:0] wrap_o,
  output logic [31:0]         version
);

  if (NUM_LEDS < 1 || NUM_LEDS > MAX_LEDS) begin : g_bad_num_leds
    $error("led_cnt_multi: NUM_LEDS=%0d outside 1..%0d", NUM_LEDS, MAX_LEDS);
  end

  if (CNT_W < 2 || CNT_W > 32) begin : g_bad_cnt_w
    $error("led_cnt_multi: CNT_W=%0d outside 2..32", CNT_W);
  end

  if (CNT_W < 32 && (DEF_DIV >> CNT_W) != 32'd0) begin : g_bad_def_div
    $error("led_cnt_multi: DEF_DIV does not fit in CNT_W=%0d bits", CNT_W);
  end

  assign version = VERS;

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    logic ld;
    // Out-of-range selects match no channel, so such writes fall away here.
    assign ld = cfg_we && (cfg_sel == 4'(i));

    led_cnt_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV[CNT_W-1:0]),
      .DEF_MODE(DEF_MODE)
    ) u_chan (
      .clk100(clk100),
      .rst   (rst),
      .ld    (ld),
      .mode  (cfg_mode),
      .div   (cfg_div),
      .led_o (leds_o[i]),
      .wrap_o(wrap_o[i])
    );
  end

endmodule

// File: tb/tb_led_cnt_multi.sv
// Bench for led_cnt_multi with NUM_LEDS=3, CNT_W=8, DEF_DIV=4.
module tb_led_cnt_multi;
  import led_cnt_pkg::*;

  localparam int          NL    = 3;
  localparam int          CW    = 8;
  localparam logic [31:0] VERSW = 32'hCCCC_0100;

  // ---------------- clock / reset / DUT ----------------
  logic          clk100;
  logic          rst;
  logic          cfg_we;
  logic [3:0]    cfg_sel;
  logic [1:0]    cfg_mode;
  logic [CW-1:0] cfg_div;
  logic [NL-1:0] leds_o;
  logic [NL-1:0] wrap_o;
  logic [31:0]   version;

  initial begin
    clk100 = 1'b0;
    forever #5 clk100 = ~clk100;
  end

  led_cnt_multi #(
    .NUM_LEDS(NL),
    .CNT_W   (CW),
    .DEF_DIV (32'd4),
    .DEF_MODE(MODE_BLINK),
    .VERS    (VERSW)
  ) dut (
    .clk100  (clk100),
    .rst     (rst),
    .cfg_we  (cfg_we),
    .cfg_sel (cfg_sel),
    .cfg_mode(cfg_mode),
    .cfg_div (cfg_div),
    .leds_o  (leds_o),
    .wrap_o  (wrap_o),
    .version (version)
  );

  // ---------------- scoreboard state ----------------
  localparam int EW = 32 + 2 * NL;
  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int ecount = 0;

  // Reference: each channel remembers its mode, divider and the edge on
  // which its phase last restarted (reset or write). Outputs at a later edge
  // follow from the period arithmetic of each mode.
  int m_mode[NL];
  int m_div[NL];
  int m_t0[NL];

  function automatic logic [1:0] exp_ch(input int c, input int e);
    int k;
    logic w, l;
    k = e - m_t0[c];
    if (k == 0) return 2'b00;
    w = ((k % (m_div[c] + 1)) == 0);
    case (m_mode[c])
      0: l = 1'b0;
      1: l = 1'b1;
      2: l = ((k / (m_div[c] + 1)) % 2) == 1;
      default: l = w;
    endcase
    if (m_mode[c] < 2) w = 1'b0;
    return {l, w};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic we, input logic [3:0] sel,
                      input logic [1:0] md, input logic [CW-1:0] dv);
    logic [NL-1:0] el, ew;
    logic [1:0] lw;
    rst      = r;
    cfg_we   = we;
    cfg_sel  = sel;
    cfg_mode = md;
    cfg_div  = dv;
    @(posedge clk100);
    ecount++;
    for (int c = 0; c < NL; c++) begin
      if (r) begin
        m_mode[c] = 2;
        m_div[c]  = 4;
        m_t0[c]   = ecount;
      end else if (we && sel == 4'(c)) begin
        m_mode[c] = int'(md);
        m_div[c]  = int'(dv);
        m_t0[c]   = ecount;
      end
      lw = exp_ch(c, ecount);
      el[c] = lw[1];
      ew[c] = lw[0];
    end
    exp_q.push_back({VERSW, el, ew});
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'd0, 2'd0, '0);
  endtask

  task automatic hand_chk(input string name, input logic [2:0] got, input logic [2:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s edge=%0d got=%b want=%b", name, ecount, got, want);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk100) begin
    logic [EW-1:0] want;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      total++;
      if ({version, leds_o, wrap_o} !== want) begin
        bad++;
        $display("FAIL scoreboard {version,leds,wrap} got=%h want=%h", {version, leds_o, wrap_o}, want);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic found;
    rst = 1'b1; cfg_we = 1'b0; cfg_sel = '0; cfg_mode = '0; cfg_div = '0;
    step(1'b1, 1'b0, 4'd0, 2'd0, '0);
    step(1'b1, 1'b0, 4'd0, 2'd0, '0);
    hand_chk("reset_leds", leds_o, 3'b000);
    hand_chk("reset_wrap", wrap_o, 3'b000);

    // 1: default blink, div=4 -> toggles/wraps at edges 5,10,15,20
    for (int i = 1; i <= 20; i++) begin
      idle();
      if (i % 5 == 0) begin
        hand_chk("t1_leds", leds_o, (i % 10 == 0) ? 3'b000 : 3'b111);
        hand_chk("t1_wrap", wrap_o, 3'b111);
      end else begin
        hand_chk("t1_wrap_lo", wrap_o, 3'b000);
      end
    end

    // 2: ch1 -> PULSE div=2 at cycle 7 of this phase
    for (int i = 1; i <= 6; i++) idle();
    step(1'b0, 1'b1, 4'd1, 2'd3, 8'd2);
    hand_chk("t2_load", {2'b00, leds_o[1]}, 3'b000);
    for (int j = 1; j <= 10; j++) begin
      idle();
      hand_chk("t2_pulse", {2'b00, leds_o[1]}, (j % 3 == 0) ? 3'b001 : 3'b000);
    end

    // 3: ch2 OFF, ON, (observe ON), BLINK div=0
    step(1'b0, 1'b1, 4'd2, 2'd0, 8'd4);
    hand_chk("t3_off", {2'b00, leds_o[2]}, 3'b000);
    step(1'b0, 1'b1, 4'd2, 2'd1, 8'd4);
    idle();
    hand_chk("t3_on", {2'b00, leds_o[2]}, 3'b001);
    step(1'b0, 1'b1, 4'd2, 2'd2, 8'd0);
    hand_chk("t3_blink_load", {2'b00, leds_o[2]}, 3'b000);
    for (int j = 1; j <= 6; j++) begin
      idle();
      hand_chk("t3_toggle", {2'b00, leds_o[2]}, (j % 2 == 1) ? 3'b001 : 3'b000);
      hand_chk("t3_wrap", {2'b00, wrap_o[2]}, 3'b001);
    end

    // 4: out-of-range select must change nothing
    step(1'b0, 1'b1, 4'd3, 2'd0, 8'd1);
    for (int j = 1; j <= 5; j++) idle();

    // 5: write ch0 on the edge its counter is terminal
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (!found) begin
        if (((ecount + 1 - m_t0[0]) % (m_div[0] + 1)) == 0) found = 1'b1;
        else idle();
      end
    end
    hand_chk("t5_terminal_found", {2'b00, found}, 3'b001);
    step(1'b0, 1'b1, 4'd0, 2'd2, 8'd3);
    hand_chk("t5_led0", {2'b00, leds_o[0]}, 3'b000);
    hand_chk("t5_wrap0", {2'b00, wrap_o[0]}, 3'b000);
    for (int j = 1; j <= 4; j++) begin
      idle();
      hand_chk("t5_led0_next", {2'b00, leds_o[0]}, (j == 4) ? 3'b001 : 3'b000);
    end

    // 6: reset mid-blink with a simultaneous write
    for (int j = 1; j <= 7; j++) idle();
    step(1'b1, 1'b1, 4'd0, 2'd1, 8'd5);
    hand_chk("t6_leds", leds_o, 3'b000);
    hand_chk("t6_wrap", wrap_o, 3'b000);
    for (int i = 1; i <= 12; i++) begin
      idle();
      if (i == 5) hand_chk("t6_default_toggle", leds_o, 3'b111);
      if (i == 10) hand_chk("t6_default_toggle2", leds_o, 3'b000);
    end

    // drain scoreboard
    for (int n = 0; n < 4; n++) begin
      if (exp_q.size() > 0) @(negedge clk100);
    end
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
